// File: rtl/lsu_frontend.sv
// lsu_frontend: buffers execute memory ops and issues them to dcache, tracks pending loads, writes back load data.
// Optional LSU_STATS_EN adds saturating hit/miss/issue-stall counters.
module lsu_frontend #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_lw,
  input  logic [4:0]  ex_regD,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_data,
  output logic        ex_ready,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  output logic        dep_stall,
  output logic [4:0]  regD_in,
  output logic [31:0] addr_in,
  output logic [31:0] store_data,
  output logic        lw,
  output logic        send_pulse,
  input  logic        hit_ack,
  input  logic        miss_send,
  input  logic [4:0]  regD_out,
  input  logic [31:0] load_data,
  input  logic        load_done_stall,
  input  logic        passive_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_regD,
  output logic [31:0] wb_data,
  output logic        ack_err
`ifdef LSU_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_stall_cyc
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_ACK = 2'd2;
  logic [1:0]    state, nxt;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          q_lw   [DEPTH];
  logic [4:0]    q_regD [DEPTH];
  logic [31:0]   q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   pending, set_mask, clr_mask;
  logic          skid_v;
  logic [4:0]    skid_regD;
  logic [31:0]   skid_data;
  logic [TW-1:0] timer;
  logic          enq, ack, accept, active, fill_ev, hit_ev, wb_any;
  assign active     = state != IDLE;
  assign enq        = ex_valid && ex_ready;
  assign ack        = state == WAIT_ACK && (hit_ack || miss_send);
  assign send_pulse = state == ISSUE && !skid_v;
  assign accept     = send_pulse && !load_done_stall && !passive_stall;
  assign lw         = active && q_lw[head];
  assign regD_in    = active ? q_regD[head] : 5'd0;
  assign addr_in    = active ? q_addr[head] : 32'd0;
  assign store_data = active ? q_data[head] : 32'd0;
  assign ex_ready   = count < CW'(DEPTH) && !(ex_lw && ex_regD != 5'd0 && pending[ex_regD]);
  assign dep_stall  = pending[rs1_idx] | pending[rs2_idx];
  assign fill_ev    = load_done_stall && regD_out != 5'd0;
  // hit destination comes from the queued op; load_data is the dcache's single return bus
  assign hit_ev     = ack && hit_ack && q_lw[head] && q_regD[head] != 5'd0;
  assign wb_any     = fill_ev || skid_v || hit_ev;
  assign set_mask   = (enq && ex_lw && ex_regD != 5'd0) ? 32'd1 << ex_regD : 32'd0;
  assign clr_mask   = wb_valid ? 32'd1 << wb_regD : 32'd0;
  always_comb begin
    nxt = state == IDLE  ? (count != '0 ? ISSUE : IDLE) :
          state == ISSUE ? (accept ? WAIT_ACK : ISSUE) :
          state == WAIT_ACK ? (ack ? (count > CW'(1) ? ISSUE : IDLE) : WAIT_ACK) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      q_lw[tail]   <= ex_lw;
      q_regD[tail] <= ex_regD;
      q_addr[tail] <= ex_addr;
      q_data[tail] <= ex_data;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pending   <= '0;
      timer     <= '0;
      ack_err   <= 1'b0;
      skid_v    <= 1'b0;
      skid_regD <= '0;
      skid_data <= '0;
      wb_valid  <= 1'b0;
      wb_regD   <= '0;
      wb_data   <= '0;
    end else begin
      state   <= nxt;
      head    <= head + AW'(ack);
      tail    <= tail + AW'(enq);
      count   <= count + CW'(enq) - CW'(ack);
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
      timer   <= (state == WAIT_ACK && !ack) ? (timer == TW'(ACK_TIMEOUT) ? timer : timer + 1'b1) : '0;
      ack_err <= ack_err | (timer == TW'(ACK_TIMEOUT));
      // a fill always takes the port first; a same-cycle hit waits in the skid
      wb_valid <= wb_any;
      if (wb_any) begin
        wb_regD <= fill_ev ? regD_out : skid_v ? skid_regD : q_regD[head];
        wb_data <= (!fill_ev && skid_v) ? skid_data : load_data;
      end
      skid_v <= (hit_ev && (fill_ev || skid_v)) || (fill_ev && skid_v);
      if (hit_ev) begin
        skid_regD <= q_regD[head];
        skid_data <= load_data;
      end
    end
  end
`ifdef LSU_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits      <= '0;
      stat_misses    <= '0;
      stat_stall_cyc <= '0;
    end else begin
      stat_hits      <= stat_hits + 32'(hit_ack && !(&stat_hits));
      stat_misses    <= stat_misses + 32'(miss_send && !(&stat_misses));
      stat_stall_cyc <= stat_stall_cyc + 32'(state == ISSUE && !accept && !(&stat_stall_cyc));
    end
  end
`endif
endmodule
